// File: rtl/mips150_uart_mmio.sv
// Memory-mapped, FIFO-buffered 8N1 UART for the MIPS150 data bus.
// Provides STATUS/RXDATA/TXDATA words, sticky error flags and an RX-pending interrupt.
module mips150_uart_mmio #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int TX_DEPTH   = 8,
   parameter int RX_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [7:0]  wdata,
   output logic [31:0] rdata,
   output logic        rx_irq,
   input  logic        serial_rx,
   output logic        serial_tx
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   // Stop bit is one cycle short in STOP: the IDLE pop cycle completes it.
   localparam logic [CW-1:0]  STOP_LAST = CW'(CLKS_PER_BIT - 2);
   localparam logic [TAW:0]   TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
   localparam logic [RAW:0]   RX_FULL_CNT = (RAW+1)'(RX_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   function automatic logic [31:0] status_word(input logic tx_ready, input logic rx_valid,
                                               input logic ovf, input logic ferr, input logic busy,
                                               input logic [7:0] rx_cnt, input logic [7:0] tx_cnt);
      status_word = {8'd0, tx_cnt, rx_cnt, 3'd0, busy, ferr, ovf, rx_valid, tx_ready};
   endfunction

   logic [7:0]     tx_mem_r [TX_DEPTH];
   logic [TAW-1:0] tx_wptr_r, tx_rptr_r;
   logic [TAW:0]   tx_count_r;
   logic           tx_full_s, tx_empty_s, tx_push_s, tx_pop_s, tx_busy_s;

   uart_state_e    tx_state_r, tx_state_nx_s;
   logic [CW-1:0]  tx_cnt_r, tx_cnt_nx_s;
   logic [2:0]     tx_bit_r, tx_bit_nx_s;
   logic [7:0]     tx_shift_r, tx_shift_nx_s;
   logic           serial_tx_r, serial_tx_nx_s;

   logic [7:0]     rx_mem_r [RX_DEPTH];
   logic [RAW-1:0] rx_wptr_r, rx_rptr_r;
   logic [RAW:0]   rx_count_r, rx_count_nx_s;
   logic           rx_full_s, rx_empty_s, rx_push_s, rx_pop_s;

   logic [1:0]     rx_sync_r;
   uart_state_e    rx_state_r, rx_state_nx_s;
   logic [CW-1:0]  rx_cnt_r, rx_cnt_nx_s;
   logic [2:0]     rx_bit_r, rx_bit_nx_s;
   logic [7:0]     rx_shift_r, rx_shift_nx_s;
   logic           rx_push_req_s, rx_ferr_set_s, rx_ovf_set_s;

   logic           rx_ovf_r, frame_err_r, rx_irq_r;
   logic [31:0]    rdata_r, rd_data_s;
   logic           clr_ovf_s, clr_ferr_s;

   assign tx_full_s  = (tx_count_r == TX_FULL_CNT);
   assign tx_empty_s = (tx_count_r == (TAW+1)'(0));
   assign rx_full_s  = (rx_count_r == RX_FULL_CNT);
   assign rx_empty_s = (rx_count_r == (RAW+1)'(0));
   assign tx_busy_s  = (tx_state_r != ST_IDLE) || !tx_empty_s;

   assign tx_push_s = wr_en && (addr == 2'd2) && !tx_full_s;
   assign rx_pop_s  = rd_en && (addr == 2'd1) && !rx_empty_s;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign rx_push_s    = rx_push_req_s && (!rx_full_s || rx_pop_s);
   assign rx_ovf_set_s = rx_push_req_s && rx_full_s && !rx_pop_s;
   assign clr_ovf_s    = wr_en && (addr == 2'd0) && wdata[2];
   assign clr_ferr_s   = wr_en && (addr == 2'd0) && wdata[3];

   assign rdata     = rdata_r;
   assign rx_irq    = rx_irq_r;
   assign serial_tx = serial_tx_r;

   // Read-data mux for the registered bus response.
   always_comb begin
      rd_data_s = 32'd0;
      case (addr)
         2'd0: rd_data_s = status_word(!tx_full_s, !rx_empty_s, rx_ovf_r, frame_err_r, tx_busy_s,
                                       8'(rx_count_r), 8'(tx_count_r));
         2'd1: begin
            if (!rx_empty_s) rd_data_s = {24'd0, rx_mem_r[rx_rptr_r]};
            else             rd_data_s = 32'd0;
         end
         default: rd_data_s = 32'd0;
      endcase
   end

   // TX shifter next-state and line value.
   always_comb begin
      tx_state_nx_s  = tx_state_r;
      tx_cnt_nx_s    = tx_cnt_r;
      tx_bit_nx_s    = tx_bit_r;
      tx_shift_nx_s  = tx_shift_r;
      serial_tx_nx_s = serial_tx_r;
      tx_pop_s       = 1'b0;
      case (tx_state_r)
         ST_IDLE: begin
            serial_tx_nx_s = 1'b1;
            if (!tx_empty_s) begin
               tx_pop_s       = 1'b1;
               tx_shift_nx_s  = tx_mem_r[tx_rptr_r];
               tx_state_nx_s  = ST_START;
               tx_cnt_nx_s    = CW'(0);
               serial_tx_nx_s = 1'b0;
            end else begin
               tx_cnt_nx_s = CW'(0);
            end
         end
         ST_START: begin
            if (tx_cnt_r == BIT_LAST) begin
               tx_state_nx_s  = ST_DATA;
               tx_cnt_nx_s    = CW'(0);
               tx_bit_nx_s    = 3'd0;
               serial_tx_nx_s = tx_shift_r[0];
            end else begin
               tx_cnt_nx_s = tx_cnt_r + CW'(1);
            end
         end
         ST_DATA: begin
            if (tx_cnt_r == BIT_LAST) begin
               tx_cnt_nx_s = CW'(0);
               if (tx_bit_r == 3'd7) begin
                  tx_state_nx_s  = ST_STOP;
                  serial_tx_nx_s = 1'b1;
               end else begin
                  tx_bit_nx_s    = tx_bit_r + 3'd1;
                  tx_shift_nx_s  = {1'b0, tx_shift_r[7:1]};
                  serial_tx_nx_s = tx_shift_r[1];
               end
            end else begin
               tx_cnt_nx_s = tx_cnt_r + CW'(1);
            end
         end
         ST_STOP: begin
            serial_tx_nx_s = 1'b1;
            if (tx_cnt_r == STOP_LAST) begin
               tx_state_nx_s = ST_IDLE;
               tx_cnt_nx_s   = CW'(0);
            end else begin
               tx_cnt_nx_s = tx_cnt_r + CW'(1);
            end
         end
         default: begin
            tx_state_nx_s  = ST_IDLE;
            serial_tx_nx_s = 1'b1;
         end
      endcase
   end

   // RX deserialiser next-state, sampling on the synchronised line.
   always_comb begin
      rx_state_nx_s = rx_state_r;
      rx_cnt_nx_s   = rx_cnt_r;
      rx_bit_nx_s   = rx_bit_r;
      rx_shift_nx_s = rx_shift_r;
      rx_push_req_s = 1'b0;
      rx_ferr_set_s = 1'b0;
      case (rx_state_r)
         ST_IDLE: begin
            if (rx_sync_r[1] && !rx_sync_r[0]) begin
               rx_state_nx_s = ST_START;
               rx_cnt_nx_s   = CW'(0);
            end else begin
               rx_cnt_nx_s = CW'(0);
            end
         end
         ST_START: begin
            if (rx_cnt_r == HALF_LAST) begin
               rx_cnt_nx_s = CW'(0);
               rx_bit_nx_s = 3'd0;
               if (!rx_sync_r[1]) rx_state_nx_s = ST_DATA;
               else               rx_state_nx_s = ST_IDLE;
            end else begin
               rx_cnt_nx_s = rx_cnt_r + CW'(1);
            end
         end
         ST_DATA: begin
            if (rx_cnt_r == BIT_LAST) begin
               rx_cnt_nx_s   = CW'(0);
               rx_shift_nx_s = {rx_sync_r[1], rx_shift_r[7:1]};
               if (rx_bit_r == 3'd7) rx_state_nx_s = ST_STOP;
               else                  rx_bit_nx_s   = rx_bit_r + 3'd1;
            end else begin
               rx_cnt_nx_s = rx_cnt_r + CW'(1);
            end
         end
         ST_STOP: begin
            if (rx_cnt_r == BIT_LAST) begin
               rx_state_nx_s = ST_IDLE;
               rx_cnt_nx_s   = CW'(0);
               if (rx_sync_r[1]) rx_push_req_s = 1'b1;
               else              rx_ferr_set_s = 1'b1;
            end else begin
               rx_cnt_nx_s = rx_cnt_r + CW'(1);
            end
         end
         default: rx_state_nx_s = ST_IDLE;
      endcase
   end

   // RX occupancy after this edge, shared by the count register and the interrupt.
   always_comb begin
      case ({rx_push_s, rx_pop_s})
         2'b10:   rx_count_nx_s = rx_count_r + (RAW+1)'(1);
         2'b01:   rx_count_nx_s = rx_count_r - (RAW+1)'(1);
         default: rx_count_nx_s = rx_count_r;
      endcase
   end

   // FIFO storage; contents are only observable through valid pointers.
   always_ff @(posedge clk) begin
      if (tx_push_s) tx_mem_r[tx_wptr_r] <= wdata;
      if (rx_push_s) rx_mem_r[rx_wptr_r] <= rx_shift_r;
   end

   // TX FIFO pointers, count and shifter state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_wptr_r   <= TAW'(0);
         tx_rptr_r   <= TAW'(0);
         tx_count_r  <= (TAW+1)'(0);
         tx_state_r  <= ST_IDLE;
         tx_cnt_r    <= CW'(0);
         tx_bit_r    <= 3'd0;
         tx_shift_r  <= 8'd0;
         serial_tx_r <= 1'b1;
      end else begin
         if (tx_push_s) tx_wptr_r <= tx_wptr_r + TAW'(1);
         if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + TAW'(1);
         case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_r <= tx_count_r + (TAW+1)'(1);
            2'b01:   tx_count_r <= tx_count_r - (TAW+1)'(1);
            default: tx_count_r <= tx_count_r;
         endcase
         tx_state_r  <= tx_state_nx_s;
         tx_cnt_r    <= tx_cnt_nx_s;
         tx_bit_r    <= tx_bit_nx_s;
         tx_shift_r  <= tx_shift_nx_s;
         serial_tx_r <= serial_tx_nx_s;
      end
   end

   // RX synchroniser, deserialiser state, FIFO pointers and sticky flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_sync_r   <= 2'b11;
         rx_state_r  <= ST_IDLE;
         rx_cnt_r    <= CW'(0);
         rx_bit_r    <= 3'd0;
         rx_shift_r  <= 8'd0;
         rx_wptr_r   <= RAW'(0);
         rx_rptr_r   <= RAW'(0);
         rx_count_r  <= (RAW+1)'(0);
         rx_ovf_r    <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         rx_sync_r  <= {rx_sync_r[0], serial_rx};
         rx_state_r <= rx_state_nx_s;
         rx_cnt_r   <= rx_cnt_nx_s;
         rx_bit_r   <= rx_bit_nx_s;
         rx_shift_r <= rx_shift_nx_s;
         if (rx_push_s) rx_wptr_r <= rx_wptr_r + RAW'(1);
         if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + RAW'(1);
         rx_count_r <= rx_count_nx_s;
         // A new error on the same edge as a clear wins, so no event is lost.
         if (rx_ovf_set_s)   rx_ovf_r <= 1'b1;
         else if (clr_ovf_s) rx_ovf_r <= 1'b0;
         else                rx_ovf_r <= rx_ovf_r;
         if (rx_ferr_set_s)   frame_err_r <= 1'b1;
         else if (clr_ferr_s) frame_err_r <= 1'b0;
         else                 frame_err_r <= frame_err_r;
      end
   end

   // Registered bus read data and interrupt.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_r  <= 32'd0;
         rx_irq_r <= 1'b0;
      end else begin
         if (rd_en) rdata_r <= rd_data_s;
         else       rdata_r <= rdata_r;
         rx_irq_r <= (rx_count_nx_s != (RAW+1)'(0));
      end
   end

endmodule

// File: tb/tb_mips150_uart_mmio.sv
// Self-checking bench for mips150_uart_mmio: queue-based behavioural model compared every
// cycle, directed scenarios with literal expectations, then randomized bus and serial traffic.
module tb_mips150_uart_mmio;
   localparam int CPB  = 10;
   localparam int HALF = CPB / 2;
   localparam int TD   = 4;
   localparam int RD   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wdata = 8'd0;
   logic [31:0] rdata;
   logic        rx_irq;
   logic        serial_rx = 1'b1;
   logic        serial_tx;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mips150_uart_mmio #(
      .CLOCK_FREQ(1000000), .BAUD_RATE(100000), .TX_DEPTH(TD), .RX_DEPTH(RD)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .wdata(wdata),
      .rdata(rdata), .rx_irq(rx_irq), .serial_rx(serial_rx), .serial_tx(serial_tx)
   );

   typedef struct { int e; logic [7:0] b; bit ok; } rx_ev_t;
   rx_ev_t     ev_q[$];
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   int         cyc = 0;
   int         tx_start = -100000;
   int         tx_next_free = 0;
   logic [7:0] tx_byte = 8'd0;
   bit         m_ovf = 1'b0, m_ferr = 1'b0;
   logic [31:0] m_rdata = 32'd0;
   logic        m_irq = 1'b0, m_tx = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: bytes in queues, line value from time since frame start.
   always @(posedge clk or negedge rst) begin : mdl
      int tx_sz, rx_sz, k;
      logic [31:0] st;
      bit popped;
      if (!rst) begin
         cyc = 0; tx_start = -100000; tx_next_free = 0; tx_byte = 8'd0;
         m_ovf = 1'b0; m_ferr = 1'b0;
         txq.delete(); rxq.delete(); ev_q.delete();
         m_rdata = 32'd0; m_irq = 1'b0; m_tx = 1'b1;
      end else begin
         cyc++;
         tx_sz = txq.size();
         rx_sz = rxq.size();
         st = {8'd0, 8'(tx_sz), 8'(rx_sz), 3'd0, (tx_sz != 0) || (cyc < tx_start + 10*CPB),
               m_ferr, m_ovf, rx_sz != 0, tx_sz < TD};
         popped = 1'b0;
         if (rd_en) begin
            if (addr == 2'd0) m_rdata = st;
            else if (addr == 2'd1 && rx_sz != 0) begin
               m_rdata = {24'd0, rxq.pop_front()};
               popped = 1'b1;
            end else m_rdata = 32'd0;
         end
         if (wr_en && addr == 2'd0) begin
            if (wdata[2]) m_ovf = 1'b0;
            if (wdata[3]) m_ferr = 1'b0;
         end
         if (ev_q.size() != 0 && ev_q[0].e == cyc) begin
            if (!ev_q[0].ok) m_ferr = 1'b1;
            else if (rx_sz < RD || popped) rxq.push_back(ev_q[0].b);
            else m_ovf = 1'b1;
            void'(ev_q.pop_front());
         end
         if (tx_sz != 0 && cyc >= tx_next_free) begin
            tx_byte = txq.pop_front();
            tx_start = cyc;
            tx_next_free = cyc + 10*CPB;
         end
         if (wr_en && addr == 2'd2 && tx_sz < TD) txq.push_back(wdata);
         m_irq = (rxq.size() != 0);
         if (cyc >= tx_start && cyc < tx_start + 10*CPB) begin
            k = (cyc - tx_start) / CPB;
            if (k == 0)      m_tx = 1'b0;
            else if (k == 9) m_tx = 1'b1;
            else             m_tx = tx_byte[k-1];
         end else m_tx = 1'b1;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("serial_tx", {31'd0, serial_tx}, {31'd0, m_tx});
      chk("rx_irq", {31'd0, rx_irq}, {31'd0, m_irq});
      chk("rdata", rdata, m_rdata);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      addr = a; wdata = d; wr_en = 1'b1;
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a);
      addr = a; rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   task automatic rx_frame(input logic [7:0] b, input bit ok);
      rx_ev_t ev;
      ev.e = cyc + 2 + HALF + 9*CPB; ev.b = b; ev.ok = ok;
      ev_q.push_back(ev);
      serial_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         serial_rx = b[i];
         tick(CPB);
      end
      serial_rx = ok;
      tick(CPB);
      serial_rx = 1'b1;
   endtask

   task automatic rx_glitch();
      serial_rx = 1'b0;
      tick(3);
      serial_rx = 1'b1;
   endtask

   logic [9:0] a5_frame = 10'b1101001010;
   logic [7:0] s4_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
   int kind;

   initial begin
      #22;
      chk("reset_serial_tx", {31'd0, serial_tx}, 32'd1);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_rx_irq", {31'd0, rx_irq}, 32'd0);
      #1 rst = 1'b1;
      tick(1);

      // Scenario 1: 0xA5 frame shape and busy release.
      bus_rd(2'd0);
      chk("s1_status_idle", rdata, 32'h0000_0001);
      bus_wr(2'd2, 8'hA5);
      tick(5);
      for (int k = 0; k < 10; k++) begin
         chk("s1_a5_bit", {31'd0, serial_tx}, {31'd0, a5_frame[k]});
         tick(10);
      end
      bus_rd(2'd0);
      chk("s1_status_done", rdata, 32'h0000_0001);

      // Scenario 2: fill TX FIFO behind a busy shifter, overflow write dropped.
      bus_wr(2'd2, 8'h01);
      for (int k = 2; k <= 5; k++) bus_wr(2'd2, 8'(k));
      bus_rd(2'd0);
      chk("s2_status_full", rdata, 32'h0004_0010);
      bus_wr(2'd2, 8'h06);
      tick(520);
      bus_rd(2'd0);
      chk("s2_status_drained", rdata, 32'h0000_0001);

      // Scenario 3: single RX frame.
      rx_frame(8'h3C, 1'b1);
      chk("s3_irq_high", {31'd0, rx_irq}, 32'd1);
      bus_rd(2'd0);
      chk("s3_status", rdata, 32'h0000_0103);
      bus_rd(2'd1);
      chk("s3_rxdata", rdata, 32'h0000_003C);
      chk("s3_irq_low", {31'd0, rx_irq}, 32'd0);

      // Scenario 4: RX overflow, order preserved, flag clear.
      for (int k = 0; k < 5; k++) begin
         rx_frame(s4_bytes[k], 1'b1);
         tick(2);
      end
      bus_rd(2'd0);
      chk("s4_status_ovf", rdata, 32'h0000_0407);
      for (int k = 0; k < 4; k++) begin
         bus_rd(2'd1);
         chk("s4_rxdata", rdata, {24'd0, s4_bytes[k]});
      end
      bus_rd(2'd1);
      chk("s4_rx_empty_read", rdata, 32'd0);
      bus_wr(2'd0, 8'h04);
      bus_rd(2'd0);
      chk("s4_status_clr", rdata, 32'h0000_0001);

      // Scenario 5: framing error and glitch rejection.
      rx_frame(8'h5A, 1'b0);
      tick(2);
      bus_rd(2'd0);
      chk("s5_status_ferr", rdata, 32'h0000_0009);
      chk("s5_irq", {31'd0, rx_irq}, 32'd0);
      bus_wr(2'd0, 8'h08);
      rx_glitch();
      tick(30);
      bus_rd(2'd0);
      chk("s5_status_glitch", rdata, 32'h0000_0001);
      bus_rd(2'd3);
      chk("s5_addr3_read", rdata, 32'd0);

      // Scenario 6: asynchronous reset mid-frame, then a fresh frame.
      bus_rd(2'd0);
      bus_wr(2'd2, 8'h96);
      tick(40);
      #2 rst = 1'b0;
      #1;
      chk("s6_reset_serial_tx", {31'd0, serial_tx}, 32'd1);
      chk("s6_reset_rdata", rdata, 32'd0);
      chk("s6_reset_rx_irq", {31'd0, rx_irq}, 32'd0);
      #3 rst = 1'b1;
      tick(1);
      bus_rd(2'd0);
      chk("s6_status_after", rdata, 32'h0000_0001);
      bus_wr(2'd2, 8'h5A);
      tick(110);
      bus_rd(2'd0);
      chk("s6_status_done", rdata, 32'h0000_0001);

      // Randomized traffic: bus accesses and serial frames in parallel.
      fork
         begin
            for (int i = 0; i < 2400; i++) begin
               addr  = 2'($urandom_range(0, 3));
               rd_en = ($urandom_range(0, 99) < 30);
               wr_en = ($urandom_range(0, 99) < 25);
               wdata = 8'($urandom);
               tick(1);
            end
            rd_en = 1'b0;
            wr_en = 1'b0;
         end
         begin
            for (int i = 0; i < 20; i++) begin
               kind = $urandom_range(0, 9);
               tick($urandom_range(2, 15));
               if (kind == 0) begin
                  rx_glitch();
                  tick(12);
               end else begin
                  rx_frame(8'($urandom), kind != 1);
               end
            end
         end
      join
      tick(600);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
